// File: rtl/mc_axi4_cmd_pkg.sv
// Shared types and constants for the command-driven AXI4 single-beat master.
package mc_axi4_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4
  } mc_cmd_state_t;

  localparam logic [1:0] AXI_BURST_INCR_C  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR_C = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR_C = 2'b11;

  localparam int unsigned STAT_BUSY_BIT_C  = 0;
  localparam int unsigned STAT_BRESP_LSB_C = 1;
  localparam int unsigned STAT_RRESP_LSB_C = 3;
  localparam int unsigned STAT_DROP_LSB_C  = 8;
  localparam int unsigned DROP_CNT_W_C     = 8;

  // AXI size code for a full-width beat (data width is 32 or 64).
  function automatic logic [2:0] axi_size_f(input int unsigned data_w);
    return (data_w == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/mc_axi4_cmd_master_if.sv
// AXI4 five-channel bundle between the command master and the memory controller.
interface mc_axi4_cmd_master_if #(
  parameter int unsigned AXI_DATA_WIDTH_C = 32,
  parameter int unsigned AXI_ADDR_WIDTH_C = 32,
  parameter int unsigned AXI_ID_WIDTH_C   = 4
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH_C / 8;

  logic [AXI_ID_WIDTH_C-1:0]   awid;
  logic [AXI_ADDR_WIDTH_C-1:0] awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;

  logic [AXI_DATA_WIDTH_C-1:0] wdata;
  logic [STRB_W-1:0]           wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic [AXI_ID_WIDTH_C-1:0]   bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  logic [AXI_ID_WIDTH_C-1:0]   arid;
  logic [AXI_ADDR_WIDTH_C-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;

  logic [AXI_ID_WIDTH_C-1:0]   rid;
  logic [AXI_DATA_WIDTH_C-1:0] rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/mc_axi4_cmd_master.sv
// Turns register-bank write/read command pulses into single-beat AXI4 transactions,
// one outstanding at a time, and reports read data and status back to the register bank.
module mc_axi4_cmd_master
  import mc_axi4_cmd_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH_C = 32,
  parameter int unsigned AXI_ADDR_WIDTH_C = 32,
  parameter int unsigned AXI_ID_WIDTH_C   = 4,
  parameter int unsigned AXI_ID_C         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_DATA_WIDTH_C-1:0] cr_axi_address,
  input  logic [AXI_DATA_WIDTH_C-1:0] cr_wdata,
  input  logic [AXI_DATA_WIDTH_C-1:0] cmd_mc_axi4_write,
  input  logic [AXI_DATA_WIDTH_C-1:0] cmd_mc_axi4_read,
  output logic [AXI_DATA_WIDTH_C-1:0] sr_mc_axi4_rdata,
  output logic [AXI_DATA_WIDTH_C-1:0] sr_mc_axi4_status,
  mc_axi4_cmd_master_if.master        axi
);

  localparam int unsigned DW = AXI_DATA_WIDTH_C;
  localparam int unsigned AW = AXI_ADDR_WIDTH_C;
  localparam int unsigned IW = AXI_ID_WIDTH_C;
  localparam int unsigned SW = DW / 8;

  localparam logic [2:0]    AXI_SIZE_C  = axi_size_f(DW);
  localparam logic [AW-1:0] ADDR_MASK_C = ~AW'((1 << AXI_SIZE_C) - 1);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_WR_REQ  = 3'(ST_WR_REQ);
  localparam logic [2:0] S_WR_RESP = 3'(ST_WR_RESP);
  localparam logic [2:0] S_RD_REQ  = 3'(ST_RD_REQ);
  localparam logic [2:0] S_RD_DATA = 3'(ST_RD_DATA);

  logic [2:0]              state, state_nxt;
  logic [AW-1:0]           addr_q, addr_nxt;
  logic [DW-1:0]           wdata_q, wdata_nxt;
  logic [DW-1:0]           rdata_q, rdata_nxt;
  logic                    awvalid_q, awvalid_nxt;
  logic                    wvalid_q, wvalid_nxt;
  logic                    bready_q, bready_nxt;
  logic                    arvalid_q, arvalid_nxt;
  logic                    rready_q, rready_nxt;
  logic                    busy_q, busy_nxt;
  logic [1:0]              bresp_q, bresp_nxt;
  logic [1:0]              rresp_q, rresp_nxt;
  logic [DROP_CNT_W_C-1:0] drop_q, drop_nxt;
  logic [DROP_CNT_W_C:0]   drop_sum;
  logic [1:0]              drops;
  logic                    wr_cmd, rd_cmd;
  logic                    aw_done, w_done;

  assign wr_cmd  = cmd_mc_axi4_write[0];
  assign rd_cmd  = cmd_mc_axi4_read[0];
  // A channel is done once it was accepted earlier or is being accepted now.
  assign aw_done = !awvalid_q || axi.awready;
  assign w_done  = !wvalid_q  || axi.wready;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    awvalid_nxt = awvalid_q;
    wvalid_nxt  = wvalid_q;
    bready_nxt  = bready_q;
    arvalid_nxt = arvalid_q;
    rready_nxt  = rready_q;
    bresp_nxt   = bresp_q;
    rresp_nxt   = rresp_q;
    drops       = 2'(wr_cmd) + 2'(rd_cmd);

    case (state)
      S_IDLE: begin
        drops = '0;
        if (wr_cmd) begin
          state_nxt   = S_WR_REQ;
          addr_nxt    = AW'(cr_axi_address) & ADDR_MASK_C;
          wdata_nxt   = cr_wdata;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          drops       = 2'(rd_cmd);
        end else if (rd_cmd) begin
          state_nxt   = S_RD_REQ;
          addr_nxt    = AW'(cr_axi_address) & ADDR_MASK_C;
          arvalid_nxt = 1'b1;
        end
      end
      S_WR_REQ: begin
        if (axi.awready) awvalid_nxt = 1'b0;
        if (axi.wready)  wvalid_nxt  = 1'b0;
        if (aw_done && w_done) begin
          state_nxt  = S_WR_RESP;
          bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (axi.bvalid) begin
          state_nxt  = S_IDLE;
          bready_nxt = 1'b0;
          bresp_nxt  = axi.bresp;
        end
      end
      S_RD_REQ: begin
        if (axi.arready) begin
          state_nxt   = S_RD_DATA;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (axi.rvalid) begin
          state_nxt  = S_IDLE;
          rready_nxt = 1'b0;
          rdata_nxt  = axi.rdata;
          rresp_nxt  = axi.rresp;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        arvalid_nxt = 1'b0;
        rready_nxt  = 1'b0;
      end
    endcase

    drop_sum = (DROP_CNT_W_C+1)'(drop_q) + (DROP_CNT_W_C+1)'(drops);
    drop_nxt = drop_sum[DROP_CNT_W_C] ? '1 : drop_sum[DROP_CNT_W_C-1:0];
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY_C;
      rresp_q   <= AXI_RESP_OKAY_C;
      drop_q    <= '0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rdata_q   <= rdata_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      busy_q    <= busy_nxt;
      bresp_q   <= bresp_nxt;
      rresp_q   <= rresp_nxt;
      drop_q    <= drop_nxt;
    end
  end

  assign axi.awid    = IW'(AXI_ID_C);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = AXI_SIZE_C;
  assign axi.awburst = AXI_BURST_INCR_C;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = {SW{1'b1}};
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arid    = IW'(AXI_ID_C);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = AXI_SIZE_C;
  assign axi.arburst = AXI_BURST_INCR_C;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign sr_mc_axi4_rdata = rdata_q;

  // Status word assembled from registered fields only.
  always_comb begin
    sr_mc_axi4_status                                       = '0;
    sr_mc_axi4_status[STAT_BUSY_BIT_C]                      = busy_q;
    sr_mc_axi4_status[STAT_BRESP_LSB_C +: 2]                = bresp_q;
    sr_mc_axi4_status[STAT_RRESP_LSB_C +: 2]                = rresp_q;
    sr_mc_axi4_status[STAT_DROP_LSB_C +: DROP_CNT_W_C]      = drop_q;
  end

  logic unused_ok;
  assign unused_ok = ^{axi.bid, axi.rid, axi.rlast, cr_axi_address,
                       cmd_mc_axi4_write[DW-1:1], cmd_mc_axi4_read[DW-1:1]};

endmodule
